// File: rtl/moesi_pkg.sv
// Shared MOESI definitions: state encodings, arbiter FSM states and the
// completion-legality check used by the request arbiter.
package moesi_pkg;

    typedef enum logic [2:0] {
        MOESI_I = 3'b000,
        MOESI_S = 3'b001,
        MOESI_E = 3'b010,
        MOESI_O = 3'b011,
        MOESI_M = 3'b100
    } state_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        GAP   = 2'd2,
        RESP  = 2'd3
    } arb_state_t;

    // A write must leave the requester in M, a read must leave it valid,
    // and encodings above M do not exist.
    function automatic logic proto_violation(input logic is_write, input logic [2:0] st);
        if (st > MOESI_M) begin
            return 1'b1;
        end
        if (is_write) begin
            return st != MOESI_M;
        end
        return st == MOESI_I;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: first set request at or after ptr
// (wrapping modulo N) wins; returns one-hot grant, its index and a hit flag.
module rr_arbiter #(
    parameter int N = 3,
    localparam int PW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [PW-1:0] ptr,
    output logic [N-1:0]  grant,
    output logic [PW-1:0] idx,
    output logic          any
);

    logic [PW-1:0] cand;

    // Scan N candidates starting at ptr; the first requesting one wins.
    always_comb begin
        grant = '0;
        idx   = '0;
        any   = 1'b0;
        cand  = '0;
        for (int k = 0; k < N; k++) begin
            cand = PW'((int'(ptr) + k) % N);
            if (!any && req[cand]) begin
                any         = 1'b1;
                grant[cand] = 1'b1;
                idx         = cand;
            end
        end
    end

endmodule

// File: rtl/moesi_request_arbiter.sv
// Front-end sequencer for the MOESI directory: buffers one request per core,
// grants round-robin, strobes the directory once, waits the settle gap and
// returns the requester's post-access state with a sticky protocol check.
module moesi_request_arbiter
    import moesi_pkg::*;
#(
    parameter int N_PROC     = 3,
    parameter int GAP_CYCLES = 1,
    localparam int PW = (N_PROC > 1) ? $clog2(N_PROC) : 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [N_PROC-1:0]     req_valid,
    input  logic [N_PROC-1:0]     req_write,
    output logic [N_PROC-1:0]     req_ready,
    output logic [PW-1:0]         dir_req_proc,
    output logic                  dir_read_req,
    output logic                  dir_write_req,
    input  logic [3*N_PROC-1:0]   dir_state,
    output logic                  resp_valid,
    output logic [PW-1:0]         resp_proc,
    output logic [2:0]            resp_state,
    output logic                  busy,
    output logic                  proto_err
);

    localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

    arb_state_t        state_q, state_d;
    logic [N_PROC-1:0] pend_valid_q, pend_valid_d;
    logic [N_PROC-1:0] pend_write_q, pend_write_d;
    logic [PW-1:0]     rr_ptr_q, rr_ptr_d;
    logic [PW-1:0]     cur_proc_q, cur_proc_d;
    logic              cur_write_q, cur_write_d;
    logic [GW-1:0]     gap_cnt_q, gap_cnt_d;
    logic              dir_read_req_q, dir_read_req_d;
    logic              dir_write_req_q, dir_write_req_d;
    logic [PW-1:0]     dir_req_proc_q, dir_req_proc_d;
    logic              resp_valid_q, resp_valid_d;
    logic [PW-1:0]     resp_proc_q, resp_proc_d;
    logic [2:0]        resp_state_q, resp_state_d;
    logic              proto_err_q, proto_err_d;

    logic [N_PROC-1:0] accept;
    logic [N_PROC-1:0] grant;
    logic [PW-1:0]     win_idx;
    logic              win_any;
    logic [2:0]        cur_dir_state;

    rr_arbiter #(.N(N_PROC)) u_rr (
        .req   (pend_valid_q),
        .ptr   (rr_ptr_q),
        .grant (grant),
        .idx   (win_idx),
        .any   (win_any)
    );

    assign accept        = req_valid & ~pend_valid_q;
    assign cur_dir_state = dir_state[3*int'(cur_proc_q) +: 3];

    // Next-state logic: slot capture, grant, strobe sequencing and completion check.
    always_comb begin
        state_d         = state_q;
        pend_valid_d    = pend_valid_q | accept;
        pend_write_d    = (pend_write_q & ~accept) | (req_write & accept);
        rr_ptr_d        = rr_ptr_q;
        cur_proc_d      = cur_proc_q;
        cur_write_d     = cur_write_q;
        gap_cnt_d       = gap_cnt_q;
        dir_read_req_d  = 1'b0;
        dir_write_req_d = 1'b0;
        dir_req_proc_d  = dir_req_proc_q;
        resp_valid_d    = 1'b0;
        resp_proc_d     = resp_proc_q;
        resp_state_d    = resp_state_q;
        proto_err_d     = proto_err_q;

        case (state_q)
            IDLE: begin
                if (win_any) begin
                    cur_proc_d      = win_idx;
                    cur_write_d     = pend_write_q[win_idx];
                    pend_valid_d    = pend_valid_d & ~grant;
                    rr_ptr_d        = (win_idx == PW'(N_PROC - 1)) ? '0 : win_idx + PW'(1);
                    dir_req_proc_d  = win_idx;
                    dir_write_req_d = pend_write_q[win_idx];
                    dir_read_req_d  = ~pend_write_q[win_idx];
                    state_d         = ISSUE;
                end
            end
            ISSUE: begin
                gap_cnt_d = GW'(GAP_CYCLES - 1);
                state_d   = GAP;
            end
            GAP: begin
                if (gap_cnt_q == '0) begin
                    resp_valid_d = 1'b1;
                    resp_proc_d  = cur_proc_q;
                    resp_state_d = cur_dir_state;
                    proto_err_d  = proto_err_q | proto_violation(cur_write_q, cur_dir_state);
                    state_d      = RESP;
                end else begin
                    gap_cnt_d = gap_cnt_q - GW'(1);
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and registered outputs; reset abandons any in-flight transaction.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q         <= IDLE;
            pend_valid_q    <= '0;
            pend_write_q    <= '0;
            rr_ptr_q        <= '0;
            cur_proc_q      <= '0;
            cur_write_q     <= 1'b0;
            gap_cnt_q       <= '0;
            dir_read_req_q  <= 1'b0;
            dir_write_req_q <= 1'b0;
            dir_req_proc_q  <= '0;
            resp_valid_q    <= 1'b0;
            resp_proc_q     <= '0;
            resp_state_q    <= '0;
            proto_err_q     <= 1'b0;
        end else begin
            state_q         <= state_d;
            pend_valid_q    <= pend_valid_d;
            pend_write_q    <= pend_write_d;
            rr_ptr_q        <= rr_ptr_d;
            cur_proc_q      <= cur_proc_d;
            cur_write_q     <= cur_write_d;
            gap_cnt_q       <= gap_cnt_d;
            dir_read_req_q  <= dir_read_req_d;
            dir_write_req_q <= dir_write_req_d;
            dir_req_proc_q  <= dir_req_proc_d;
            resp_valid_q    <= resp_valid_d;
            resp_proc_q     <= resp_proc_d;
            resp_state_q    <= resp_state_d;
            proto_err_q     <= proto_err_d;
        end
    end

    assign req_ready     = ~pend_valid_q;
    assign dir_req_proc  = dir_req_proc_q;
    assign dir_read_req  = dir_read_req_q;
    assign dir_write_req = dir_write_req_q;
    assign resp_valid    = resp_valid_q;
    assign resp_proc     = resp_proc_q;
    assign resp_state    = resp_state_q;
    assign busy          = (state_q != IDLE);
    assign proto_err     = proto_err_q;

endmodule

// File: tb/tb_moesi_request_arbiter.sv
// Directed bench for moesi_request_arbiter with a behavioural MOESI directory
// and a scoreboard of expected {core, state} completions.
module tb_moesi_request_arbiter;
    import moesi_pkg::*;

    localparam int N = 3;

    typedef struct packed {
        logic [1:0] proc;
        logic [2:0] st;
    } exp_t;

    typedef struct {
        logic [1:0] proc;
        logic       wr;
        int         cyc;
    } iss_t;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic [N-1:0] req_valid = '0;
    logic [N-1:0] req_write = '0;
    logic [N-1:0] req_ready;
    logic [1:0]   dir_req_proc;
    logic         dir_read_req;
    logic         dir_write_req;
    logic [3*N-1:0] dir_state;
    logic         resp_valid;
    logic [1:0]   resp_proc;
    logic [2:0]   resp_state;
    logic         busy;
    logic         proto_err;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    exp_t expq[$];
    iss_t iss_q[$];
    int   rsp_cyc_q[$];

    moesi_request_arbiter #(.N_PROC(N), .GAP_CYCLES(1)) dut (
        .clk           (clk),
        .reset         (reset),
        .req_valid     (req_valid),
        .req_write     (req_write),
        .req_ready     (req_ready),
        .dir_req_proc  (dir_req_proc),
        .dir_read_req  (dir_read_req),
        .dir_write_req (dir_write_req),
        .dir_state     (dir_state),
        .resp_valid    (resp_valid),
        .resp_proc     (resp_proc),
        .resp_state    (resp_state),
        .busy          (busy),
        .proto_err     (proto_err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Behavioural directory; stub_bad makes writes leave the writer in I.
    logic [2:0] dir_st [N];
    logic       stub_bad = 1'b0;
    int         dm_p;
    logic       dm_others;
    assign dir_state = {dir_st[2], dir_st[1], dir_st[0]};

    always_comb begin
        dm_p      = int'(dir_req_proc);
        dm_others = 1'b0;
        for (int j = 0; j < N; j++)
            if (j != dm_p && dir_st[j] != MOESI_I) dm_others = 1'b1;
    end

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int j = 0; j < N; j++) dir_st[j] <= MOESI_I;
        end else if (dir_write_req) begin
            for (int j = 0; j < N; j++)
                dir_st[j] <= (j == dm_p) ? (stub_bad ? MOESI_I : MOESI_M) : MOESI_I;
        end else if (dir_read_req && dir_st[dm_p] == MOESI_I) begin
            for (int j = 0; j < N; j++) begin
                if (j == dm_p) dir_st[j] <= dm_others ? MOESI_S : MOESI_E;
                else if (dir_st[j] == MOESI_M) dir_st[j] <= MOESI_O;
                else if (dir_st[j] == MOESI_E) dir_st[j] <= MOESI_S;
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
        end
    endtask

    // Monitor: log strobes, score responses against the expected queue.
    always @(negedge clk) begin
        if (dir_read_req || dir_write_req) begin
            check("strobe_excl", 32'(dir_read_req & dir_write_req), 32'd0);
            check("proc_range", 32'(dir_req_proc >= 2'(N)), 32'd0);
            iss_q.push_back('{dir_req_proc, dir_write_req, cyc});
        end
        if (resp_valid) begin
            rsp_cyc_q.push_back(cyc);
            check("resp_expected", 32'(expq.size() != 0), 32'd1);
            if (expq.size() != 0) begin
                exp_t e;
                e = expq.pop_front();
                check("resp_proc", 32'(resp_proc), 32'(e.proc));
                check("resp_state", 32'(resp_state), 32'(e.st));
            end
        end
    end

    task automatic expect_resp(input int p, input logic [2:0] st);
        exp_t e;
        e.proc = 2'(p);
        e.st   = st;
        expq.push_back(e);
    endtask

    task automatic clear_logs();
        iss_q.delete();
        rsp_cyc_q.delete();
    endtask

    task automatic do_reset();
        req_valid = '0;
        req_write = '0;
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        expq.delete();
        clear_logs();
    endtask

    task automatic do_req(input int core, input logic wr);
        int   n;
        logic acc;
        n = 0;
        acc = 1'b0;
        @(negedge clk);
        req_valid[core] = 1'b1;
        req_write[core] = wr;
        while (!acc && n < 100) begin
            acc = req_ready[core];
            @(posedge clk);
            #1;
            n++;
        end
        req_valid[core] = 1'b0;
        check("req_accept", 32'(acc), 32'd1);
    endtask

    task automatic wait_idle(input string tag);
        int   n;
        logic done;
        n = 0;
        done = 1'b0;
        while (!done && n < 300) begin
            @(negedge clk);
            #1;
            n++;
            if (expq.size() == 0 && !busy && req_valid == '0) done = 1'b1;
        end
        check({tag, "_idle"}, 32'(done), 32'd1);
    endtask

    task automatic wait_issues(input int cnt);
        int n;
        n = 0;
        while (iss_q.size() < cnt && n < 200) begin
            @(negedge clk);
            #1;
            n++;
        end
        check("issue_count_reached", 32'(iss_q.size() >= cnt), 32'd1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [2:0] seq_st [6];
        seq_st[0] = MOESI_E; seq_st[1] = MOESI_M; seq_st[2] = MOESI_S;
        seq_st[3] = MOESI_M; seq_st[4] = MOESI_S; seq_st[5] = MOESI_M;

        // Reset state
        do_reset();
        #1;
        check("rst_ready", 32'(req_ready), 32'h7);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_resp_valid", 32'(resp_valid), 32'd0);
        check("rst_rd", 32'(dir_read_req), 32'd0);
        check("rst_wr", 32'(dir_write_req), 32'd0);
        check("rst_dproc", 32'(dir_req_proc), 32'd0);
        check("rst_rproc", 32'(resp_proc), 32'd0);
        check("rst_rstate", 32'(resp_state), 32'd0);
        check("rst_perr", 32'(proto_err), 32'd0);

        // 1: single read from core 0
        expect_resp(0, MOESI_E);
        do_req(0, 1'b0);
        wait_idle("t1");
        check("t1_n_issue", 32'(iss_q.size()), 32'd1);
        check("t1_n_resp", 32'(rsp_cyc_q.size()), 32'd1);
        if (iss_q.size() == 1 && rsp_cyc_q.size() == 1) begin
            check("t1_proc", 32'(iss_q[0].proc), 32'd0);
            check("t1_is_read", 32'(iss_q[0].wr), 32'd0);
            check("t1_latency", 32'(rsp_cyc_q[0] - iss_q[0].cyc), 32'd2);
        end
        check("t1_perr", 32'(proto_err), 32'd0);

        // 2: simultaneous reads from all cores
        do_reset();
        expect_resp(0, MOESI_E);
        expect_resp(1, MOESI_S);
        expect_resp(2, MOESI_S);
        @(negedge clk);
        req_valid = 3'b111;
        req_write = 3'b000;
        @(posedge clk); #1;
        req_valid = '0;
        check("t2_ready_e0", 32'(req_ready), 32'h0);
        @(posedge clk); #1;
        check("t2_ready_e1", 32'(req_ready), 32'h1);
        repeat (4) @(posedge clk);
        #1;
        check("t2_ready_e5", 32'(req_ready), 32'h3);
        repeat (4) @(posedge clk);
        #1;
        check("t2_ready_e9", 32'(req_ready), 32'h7);
        wait_idle("t2");
        check("t2_n_issue", 32'(iss_q.size()), 32'd3);
        if (iss_q.size() == 3) begin
            for (int i = 0; i < 3; i++) check("t2_order", 32'(iss_q[i].proc), 32'(i));
            check("t2_gap01", 32'(iss_q[1].cyc - iss_q[0].cyc), 32'd4);
            check("t2_gap12", 32'(iss_q[2].cyc - iss_q[1].cyc), 32'd4);
        end

        // 3: cores 0 and 2 hold valid, core 1 idle
        do_reset();
        expect_resp(0, MOESI_E);
        expect_resp(2, MOESI_S);
        expect_resp(0, MOESI_S);
        expect_resp(2, MOESI_S);
        @(negedge clk);
        req_valid = 3'b101;
        req_write = 3'b000;
        wait_issues(3);
        req_valid[0] = 1'b0;
        wait_issues(4);
        req_valid[2] = 1'b0;
        wait_idle("t3");
        check("t3_n_issue", 32'(iss_q.size()), 32'd4);
        if (iss_q.size() == 4) begin
            check("t3_g0", 32'(iss_q[0].proc), 32'd0);
            check("t3_g1", 32'(iss_q[1].proc), 32'd2);
            check("t3_g2", 32'(iss_q[2].proc), 32'd0);
            check("t3_g3", 32'(iss_q[3].proc), 32'd2);
        end

        // 4: read/write sequence across cores
        do_reset();
        for (int i = 0; i < 6; i++) begin
            expect_resp(i / 2, seq_st[i]);
            do_req(i / 2, logic'(i % 2));
            wait_idle("t4");
        end
        check("t4_perr", 32'(proto_err), 32'd0);

        // 5: directory stub leaves writer in I -> sticky protocol error
        do_reset();
        stub_bad = 1'b1;
        expect_resp(0, MOESI_I);
        do_req(0, 1'b1);
        wait_idle("t5a");
        stub_bad = 1'b0;
        check("t5_perr_set", 32'(proto_err), 32'd1);
        expect_resp(1, MOESI_E);
        do_req(1, 1'b0);
        wait_idle("t5b");
        check("t5_perr_sticky1", 32'(proto_err), 32'd1);
        expect_resp(1, MOESI_M);
        do_req(1, 1'b1);
        wait_idle("t5c");
        check("t5_perr_sticky2", 32'(proto_err), 32'd1);
        do_reset();
        #1;
        check("t5_perr_cleared", 32'(proto_err), 32'd0);

        // 6: reset during ISSUE
        do_req(0, 1'b1);
        begin
            int n;
            n = 0;
            while (!dir_write_req && n < 20) begin
                @(negedge clk);
                #1;
                n++;
            end
            check("t6_reached_issue", 32'(dir_write_req), 32'd1);
        end
        reset = 1'b1;
        #1;
        check("t6_wr_dropped", 32'(dir_write_req), 32'd0);
        check("t6_busy_cleared", 32'(busy), 32'd0);
        check("t6_ready", 32'(req_ready), 32'h7);
        expq.delete();
        clear_logs();
        repeat (2) @(negedge clk);
        reset = 1'b0;
        repeat (8) @(negedge clk);
        #1;
        check("t6_no_resp", 32'(rsp_cyc_q.size()), 32'd0);
        check("t6_no_issue", 32'(iss_q.size()), 32'd0);
        expect_resp(0, MOESI_E);
        expect_resp(1, MOESI_S);
        expect_resp(2, MOESI_S);
        @(negedge clk);
        req_valid = 3'b111;
        req_write = 3'b000;
        @(posedge clk); #1;
        req_valid = '0;
        wait_idle("t6");
        check("t6_n_issue", 32'(iss_q.size()), 32'd3);
        if (iss_q.size() == 3) begin
            for (int i = 0; i < 3; i++) check("t6_order", 32'(iss_q[i].proc), 32'(i));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
